tis_port_mux: RTL and testbench
===============================

# tis_port_mux

Parametrised multi-channel receive port for a TIS-100 node: buffers words arriving from `CHANNELS` neighbour links in per-channel FIFOs and serves the node's read requests in SPECIFIC, ANY, LAST or NIL mode. It replaces the single unbuffered rendezvous per direction with depth-configurable buffering, plus a hardware ANY/LAST resolver. It sits between a node's execution core and its incoming neighbour buses in a grid of any size.

## Interface
- `CHANNELS`, 4: number of input links; index 0..3 = LEFT, RIGHT, UP, DOWN, which is also the ANY priority order.
- `DATA_W`, 11: signed word width.
- `DEPTH`, 2: entries per channel FIFO; power of two, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in `CHANNELS`: per-channel word offered.
- `in_data` in `CHANNELS*DATA_W`: channel k occupies bits [k*DATA_W +: DATA_W].
- `in_ready` out `CHANNELS`: per-channel FIFO not full.
- `rd_req` in 1: core requests one word; held until `rd_valid`.
- `rd_mode` in 2: 0 SPEC, 1 ANY, 2 LAST, 3 NIL.
- `rd_sel` in `$clog2(CHANNELS)`: channel for SPEC.
- `rd_valid` out 1: one-cycle pulse, read completed.
- `rd_data` out `DATA_W`: word returned; valid while `rd_valid`.
- `rd_chan` out `$clog2(CHANNELS)`: channel served; 0 for NIL.
- `last_chan` out `$clog2(CHANNELS)`: channel most recently served by ANY.
- `last_valid` out 1: `last_chan` meaningful.

## Operation
- Push: channel k writes when `in_valid[k] && in_ready[k]`. `in_ready[k]` = !full[k], from registered state only. No push into a full FIFO, even if it is popped in the same cycle.
- Pop decision is made on cycle t from registered FIFO state. Results are registered and visible on t+1.
  - SPEC: satisfiable if FIFO[`rd_sel`] is non-empty. If `rd_sel` ≥ `CHANNELS`, the read behaves as NIL.
  - ANY: selects the lowest-index non-empty FIFO. Sets `last_chan` to that index and `last_valid`=1.
  - LAST: with `last_valid`=1, behaves as SPEC on `last_chan`. With `last_valid`=0, behaves as NIL.
  - NIL: always satisfiable. `rd_data`=0, `rd_chan`=0, no pop.
- An unsatisfiable request stalls: no pop, `rd_valid`=0. The request is re-evaluated every cycle while `rd_req` is held. `rd_mode` and `rd_sel` must be stable while `rd_req` is high.
- One read is served per `rd_valid` pulse. Back-to-back reads at one word per cycle are supported if the core keeps `rd_req` high.
- A push and a pop on the same non-full, non-empty FIFO in the same cycle leave its count unchanged.
- No bypass: a word pushed into an empty FIFO is not poppable until the following cycle.
- Data is passed through unmodified. There is no saturation or sign handling.

## Timing
- Reset values:
  - `in_ready` all 1
  - `rd_valid` 0
  - `rd_data` 0
  - `rd_chan` 0
  - `last_chan` 0
  - `last_valid` 0
  - all FIFOs empty
- Latency from input to output is at least 2 cycles: push at t, pop decision at t+1, `rd_valid` at t+2.
- A NIL read, or LAST with `last_valid`=0, completes with `rd_valid` one cycle after `rd_req` is sampled.
- Full boundary: `in_ready[k]` drops in the cycle after the DEPTH-th word is accepted. It rises in the cycle after the first pop from a full FIFO.
- Pointer wrap-around is modulo `DEPTH`. The count register is `$clog2(DEPTH)+1` bits wide.
- Reset asserted mid-operation takes effect on the next edge. All buffered words are discarded, and a pending `rd_req` must be reissued.

## Structure
- Package `tis_port_pkg` holds:
  - `rd_mode` constants MODE_SPEC, MODE_ANY, MODE_LAST, MODE_NIL
  - default `DATA_W`=11
  - direction index constants LEFT=0, RIGHT=1, UP=2, DOWN=3
- Sub-module `tis_port_fifo` is a single-channel synchronous FIFO with push, pop, full, empty and head data. It is instantiated `CHANNELS` times via generate.
- The top level holds the pop-select priority logic, the LAST register and the output registers.

## Test plan
- SPEC: push 5 on channel 2 at cycle 0; `rd_req` SPEC `rd_sel`=2 from cycle 0 → `rd_valid` at cycle 2, `rd_data`=5, `rd_chan`=2.
- ANY priority: preload channel 3=-7 and channel 1=12, then ANY → returns 12, `last_chan`=1; a second ANY → returns -7, `last_chan`=3.
- LAST and NIL: after reset, LAST → `rd_data`=0 one cycle later, `last_valid`=0. After an ANY from channel 0, LAST with channel 0 empty stalls until 999 is pushed, then returns 999.
- Full and wrap: with `DEPTH`=2, hold `in_valid` on channel 0 with 1, 2, 3 → `in_ready[0]`=0 after 2 accepts. Three reads return 1, 2, 3 in order across pointer wrap.
- Reset mid-operation: two words buffered, `rst_n`=0 for one cycle → all outputs at reset values, and a subsequent SPEC read stalls.

Source files
------------

// File: rtl/tis_port_pkg.sv
// tis_port_pkg: shared constants for the TIS-100 node receive port.
// Read modes, default word width and neighbour direction indices.
package tis_port_pkg;

  typedef enum logic [1:0] {
    MODE_SPEC = 2'd0,
    MODE_ANY  = 2'd1,
    MODE_LAST = 2'd2,
    MODE_NIL  = 2'd3
  } rd_mode_e;

  localparam int DEF_DATA_W = 11;

  localparam int LEFT  = 0;
  localparam int RIGHT = 1;
  localparam int UP    = 2;
  localparam int DOWN  = 3;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tis_port_mux_if.sv
// tis_port_mux_if: neighbour link inputs and core read port bundle.
// master drives words and requests; slave is the receive port.
interface tis_port_mux_if
  import tis_port_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = DEF_DATA_W
);
  localparam int SEL_W = sel_w(CHANNELS);

  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS*DATA_W-1:0] in_data;
  logic [CHANNELS-1:0]        in_ready;
  logic                       rd_req;
  logic [1:0]                 rd_mode;
  logic [SEL_W-1:0]           rd_sel;
  logic                       rd_valid;
  logic [DATA_W-1:0]          rd_data;
  logic [SEL_W-1:0]           rd_chan;
  logic [SEL_W-1:0]           last_chan;
  logic                       last_valid;

  modport master (
    output in_valid, in_data, rd_req, rd_mode, rd_sel,
    input  in_ready, rd_valid, rd_data, rd_chan,
    input  last_chan, last_valid
  );

  modport slave (
    input  in_valid, in_data, rd_req, rd_mode, rd_sel,
    output in_ready, rd_valid, rd_data, rd_chan,
    output last_chan, last_valid
  );
endinterface

// File: rtl/tis_port_fifo.sv
// tis_port_fifo: single-channel synchronous FIFO, no bypass.
// Push into a full FIFO is refused even if it pops that cycle.
module tis_port_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/tis_port_mux.sv
// tis_port_mux: buffered multi-link receive port for a TIS-100 node.
// Serves SPEC/ANY/LAST/NIL reads from per-channel FIFOs.
module tis_port_mux
  import tis_port_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  tis_port_mux_if.slave bus
);
  localparam int SEL_W = sel_w(CHANNELS);

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] pop;
  logic [DATA_W-1:0]   head [CHANNELS];

  rd_mode_e         mode;
  logic [SEL_W-1:0] tgt;
  logic             nil;
  logic             serve;
  logic             hit;

  assign mode         = rd_mode_e'(bus.rd_mode);
  assign bus.in_ready = ~full;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    tis_port_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.in_valid[k]),
      .pop   (pop[k]),
      .wdata (bus.in_data[k*DATA_W +: DATA_W]),
      .full  (full[k]),
      .empty (empty[k]),
      .head  (head[k])
    );
  end

  // Decision uses registered FIFO state only, so no same-cycle bypass.
  always_comb begin
    tgt = '0;
    nil = 1'b0;
    hit = 1'b0;
    unique case (mode)
      MODE_SPEC: begin
        if (32'(bus.rd_sel) < CHANNELS) begin
          tgt = bus.rd_sel;
          hit = !empty[tgt];
        end else begin
          nil = 1'b1;
        end
      end
      MODE_ANY: begin
        for (int k = CHANNELS - 1; k >= 0; k--) begin
          if (!empty[k]) begin
            tgt = SEL_W'(k);
            hit = 1'b1;
          end
        end
      end
      MODE_LAST: begin
        if (bus.last_valid) begin
          tgt = bus.last_chan;
          hit = !empty[tgt];
        end else begin
          nil = 1'b1;
        end
      end
      default: nil = 1'b1;
    endcase
    serve = bus.rd_req && (hit || nil);
    pop = '0;
    pop[tgt] = serve && !nil;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_valid   <= 1'b0;
      bus.rd_data    <= '0;
      bus.rd_chan    <= '0;
      bus.last_chan  <= '0;
      bus.last_valid <= 1'b0;
    end else begin
      bus.rd_valid <= serve;
      bus.rd_data  <= (serve && !nil) ? head[tgt] : '0;
      bus.rd_chan  <= (serve && !nil) ? tgt : '0;
      if (serve && mode == MODE_ANY) begin
        bus.last_chan  <= tgt;
        bus.last_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tis_port_mux.sv
// tb_tis_port_mux: scoreboard bench for the TIS-100 receive port.
// Expected words are queued at request time and checked on rd_valid.
module tb_tis_port_mux;
  import tis_port_pkg::*;

  localparam int CH = 4;
  localparam int DW = 11;
  localparam int DP = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [DW+1:0] sb [$];

  tis_port_mux_if #(.CHANNELS(CH), .DATA_W(DW)) bus ();

  tis_port_mux #(
    .CHANNELS (CH),
    .DATA_W   (DW),
    .DEPTH    (DP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 32'(bus.rd_data), 32'hdead);
      end else begin
        logic [DW+1:0] e;
        e = sb.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(e[DW-1:0]));
        chk("rd_chan", 32'(bus.rd_chan), 32'(e[DW+1:DW]));
      end
    end
  end

  task automatic push(input int ch, input logic [DW-1:0] v);
    int n;
    n = 0;
    bus.in_valid[ch] = 1'b1;
    bus.in_data[ch*DW +: DW] = v;
    while (!bus.in_ready[ch] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'(n), 0);
    tick();
    bus.in_valid[ch] = 1'b0;
  endtask

  task automatic rd(input rd_mode_e m, input int sel,
                    input logic [DW-1:0] d, input int c, input int lat);
    int n;
    logic [1:0] cc;
    cc = 2'(c);
    sb.push_back({cc, d});
    bus.rd_mode = m;
    bus.rd_sel  = 2'(sel);
    bus.rd_req  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.rd_valid && n < 60);
    bus.rd_req = 1'b0;
    if (!bus.rd_valid) chk("rd_timeout", 32'(n), 0);
    if (lat >= 0) chk("rd_lat", 32'(n), 32'(lat));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'hf);
    chk({tag, "_valid"}, 32'(bus.rd_valid), 0);
    chk({tag, "_data"}, 32'(bus.rd_data), 0);
    chk({tag, "_chan"}, 32'(bus.rd_chan), 0);
    chk({tag, "_lchan"}, 32'(bus.last_chan), 0);
    chk({tag, "_lvalid"}, 32'(bus.last_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_mode  = MODE_NIL;
    bus.rd_sel   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_reset("rst");

    rd(MODE_LAST, 0, '0, 0, 1);
    chk("last_after_rst", 32'(bus.last_valid), 0);
    rd(MODE_NIL, 0, '0, 0, 1);

    // SPEC: push and request in the same cycle -> rd_valid two cycles later
    bus.in_valid[UP] = 1'b1;
    bus.in_data[UP*DW +: DW] = 11'd5;
    bus.rd_mode = MODE_SPEC;
    bus.rd_sel  = 2'(UP);
    bus.rd_req  = 1'b1;
    sb.push_back({2'(UP), 11'd5});
    tick();
    bus.in_valid[UP] = 1'b0;
    chk("spec_nobypass", 32'(bus.rd_valid), 0);
    tick();
    chk("spec_lat2", 32'(bus.rd_valid), 1);
    bus.rd_req = 1'b0;
    tick();

    push(DOWN, -11'sd7);
    push(RIGHT, 11'sd12);
    rd(MODE_ANY, 0, 11'sd12, RIGHT, 1);
    chk("any1_last", 32'(bus.last_chan), RIGHT);
    chk("any1_lval", 32'(bus.last_valid), 1);
    rd(MODE_ANY, 0, -11'sd7, DOWN, 1);
    chk("any2_last", 32'(bus.last_chan), DOWN);

    push(LEFT, 11'd4);
    rd(MODE_ANY, 0, 11'd4, LEFT, 1);
    chk("any3_last", 32'(bus.last_chan), LEFT);
    fork
      rd(MODE_LAST, 0, 11'd999, LEFT, 6);
      begin
        repeat (4) tick();
        push(LEFT, 11'd999);
      end
    join

    // Full boundary and pointer wrap on channel 0
    bus.in_valid[LEFT] = 1'b1;
    bus.in_data[LEFT*DW +: DW] = 11'd1;
    tick();
    chk("full_rdy1", 32'(bus.in_ready[LEFT]), 1);
    bus.in_data[LEFT*DW +: DW] = 11'd2;
    tick();
    chk("full_rdy0", 32'(bus.in_ready[LEFT]), 0);
    bus.in_data[LEFT*DW +: DW] = 11'd3;
    tick();
    tick();
    chk("full_hold", 32'(bus.in_ready[LEFT]), 0);
    rd(MODE_SPEC, LEFT, 11'd1, LEFT, 1);
    chk("full_rise", 32'(bus.in_ready[LEFT]), 1);
    tick();
    bus.in_valid[LEFT] = 1'b0;
    chk("full_again", 32'(bus.in_ready[LEFT]), 0);
    rd(MODE_SPEC, LEFT, 11'd2, LEFT, 1);
    rd(MODE_SPEC, LEFT, 11'd3, LEFT, 1);
    chk("drained", 32'(bus.in_ready), 32'hf);

    // Reset mid-operation discards buffered words
    push(RIGHT, 11'd10);
    push(RIGHT, 11'd20);
    rd(MODE_ANY, 0, 11'd10, RIGHT, 1);
    push(RIGHT, 11'd30);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("mid");
    bus.rd_mode = MODE_SPEC;
    bus.rd_sel  = 2'(RIGHT);
    bus.rd_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_after_rst", 32'(bus.rd_valid), 0);
    end
    bus.rd_req = 1'b0;
    tick();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
